imem_loader: RTL

Runtime instruction-memory loader for simpleMIPS. It receives a program image as a byte stream and writes it word-by-word into the instruction memory write port used by the fetch stage. It holds the CPU in reset until the image is complete, then releases it so fetch starts from a freshly loaded memory. It is the writer counterpart of the fetch-side instruction memory reader and replaces $readmemh preloading for on-board and streamed-image tests.

---
 rtl/imem_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into instruction memory one word at a time,
// holding the CPU in reset until the whole image has been written.
module imem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              start_i,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        StHdrHi,
        StHdrLo,
        StData,
        StFin,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         count_q;
    logic [15:0]         idx_q;
    logic [1:0]          bcnt_q;
    logic [31:0]         asm_q;
    logic                in_ready_q;
    logic                im_we_q;
    logic [ADDR_W-1:0]   im_addr_q;
    logic [31:0]         im_wdata_q;
    logic                cpu_rst_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic                accept;
    logic [31:0]         word;
    logic [32:0]         tgt;
    logic                in_range;
    logic                last_word;
    logic [15:0]         count_full;

    assign accept     = in_valid_i && in_ready_q;
    assign word       = {asm_q[23:0], in_data_i};
    assign count_full = {count_q[15:8], in_data_i};
    // Wide sum so an address past the top of memory is detected rather than wrapped.
    assign tgt        = 33'(BASE_ADDR) + 33'(idx_q);
    assign in_range   = tgt < (33'd1 << ADDR_W);
    assign last_word  = (17'(idx_q) + 17'd1) == 17'(count_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StHdrHi: if (accept) state_d = StHdrLo;
            StHdrLo: if (accept) state_d = (count_full == 16'd0) ? StFin : StData;
            StData:  if (accept && bcnt_q == 2'd3 && last_word) state_d = StFin;
            StFin:   state_d = StDone;
            StDone:  if (start_i) state_d = StHdrHi;
            default: state_d = StHdrHi;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StHdrHi;
            count_q    <= 16'd0;
            idx_q      <= 16'd0;
            bcnt_q     <= 2'd0;
            asm_q      <= 32'd0;
            in_ready_q <= 1'b1;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= 32'd0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == StHdrHi) || (state_d == StHdrLo) || (state_d == StData);
            cpu_rst_q  <= (state_d != StDone);
            busy_q     <= (state_d != StDone);
            done_q     <= (state_d == StDone);
            im_we_q    <= 1'b0;
            case (state_q)
                StHdrHi: begin
                    if (accept) count_q[15:8] <= in_data_i;
                end
                StHdrLo: begin
                    if (accept) begin
                        count_q[7:0] <= in_data_i;
                        idx_q        <= 16'd0;
                        bcnt_q       <= 2'd0;
                    end
                end
                StData: begin
                    if (accept) begin
                        asm_q  <= word;
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            idx_q <= idx_q + 16'd1;
                            // Out-of-range words are still consumed to keep the stream framed.
                            if (in_range) begin
                                im_we_q    <= 1'b1;
                                im_addr_q  <= ADDR_W'(tgt);
                                im_wdata_q <= word;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                StDone: begin
                    if (start_i) begin
                        idx_q <= 16'd0;
                        err_q <= 1'b0;
                        asm_q <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o = in_ready_q;
    assign im_we_o    = im_we_q;
    assign im_addr_o  = im_addr_q;
    assign im_wdata_o = im_wdata_q;
    assign cpu_rst_o  = cpu_rst_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule
